// File: rtl/motion_sequencer_if.sv
// Request/handshake and motor-command bundle between the core FSM (master)
// and the motion sequencer (slave).
interface motion_sequencer_if;
  logic       en_tracking;
  logic       en_brake;
  logic       en_reverse;
  logic       en_fbrake;
  logic       en_uturn;
  logic [7:0] trk_duty_l;
  logic [7:0] trk_duty_r;
  logic       line_center;
  logic [7:0] duty_l;
  logic [7:0] duty_r;
  logic       dir_l;
  logic       dir_r;
  logic       motor_brake;
  logic       brake_finished;
  logic       reverse_finished;
  logic       fbrake_finished;
  logic       uturn_finished;
  logic       uturn_timeout;

  modport master (
    output en_tracking, en_brake, en_reverse, en_fbrake, en_uturn,
    output trk_duty_l, trk_duty_r, line_center,
    input  duty_l, duty_r, dir_l, dir_r, motor_brake,
    input  brake_finished, reverse_finished, fbrake_finished,
    input  uturn_finished, uturn_timeout
  );

  modport slave (
    input  en_tracking, en_brake, en_reverse, en_fbrake, en_uturn,
    input  trk_duty_l, trk_duty_r, line_center,
    output duty_l, duty_r, dir_l, dir_r, motor_brake,
    output brake_finished, reverse_finished, fbrake_finished,
    output uturn_finished, uturn_timeout
  );
endinterface

// File: rtl/motion_sequencer.sv
// Maneuver arbiter/sequencer: per-phase timers, finished handshakes, motor commands.
// Optional SOFT_START_EN: duty ramps up by 1 per tick after entering TRACK/REVERSE/UTURN.
module motion_sequencer #(
  parameter int          TICK_DIV    = 50000,
  parameter int          BRAKE_T     = 300,
  parameter int          REVERSE_T   = 800,
  parameter int          FBRAKE_T    = 200,
  parameter int          UTURN_MIN_T = 400,
  parameter int          UTURN_MAX_T = 3000,
  parameter logic [7:0]  REV_DUTY    = 8'd120,
  parameter logic [7:0]  TURN_DUTY   = 8'd140
) (
  input logic               clk,
  input logic               rst,
  motion_sequencer_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [15:0]   BRAKE_LAST = 16'(BRAKE_T - 1);
  localparam logic [15:0]   REV_LAST   = 16'(REVERSE_T - 1);
  localparam logic [15:0]   FB_LAST    = 16'(FBRAKE_T - 1);
  localparam logic [15:0]   UT_MIN     = 16'(UTURN_MIN_T);
  localparam logic [15:0]   UT_LAST    = 16'(UTURN_MAX_T - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TRACK, S_BRAKE, S_REVERSE, S_FBRAKE, S_UTURN
  } state_t;

  state_t          state_r, state_n_s, sel_s;
  logic [PW-1:0]   presc_r;
  logic [15:0]     ticks_r;
  logic            tick_s;
  logic            brake_fin_r, rev_fin_r, fb_fin_r, ut_fin_r, ut_to_r;
  logic            armed_brake_s, armed_rev_s, armed_fb_s, armed_ut_s;
  logic            done_brake_s, done_rev_s, done_fb_s, done_ut_s, timeout_s;
  logic [7:0]      duty_l_r, duty_r_r, tgt_l_s, tgt_r_s;
  logic            dir_l_r, dir_r_r, brake_r, dir_l_s, dir_r_s, brake_s;

`ifdef SOFT_START_EN
  logic            entry_r;

  function automatic logic [7:0] ramp_step(input logic [7:0] cur, input logic [7:0] tgt,
                                           input logic tick);
    if (tgt < cur) begin
      ramp_step = tgt;
    end else if (tick && (cur != tgt)) begin
      ramp_step = cur + 8'd1;
    end else begin
      ramp_step = cur;
    end
  endfunction
`endif

  // Request arming and priority selection used from IDLE and TRACK.
  always_comb begin
    tick_s        = (presc_r == PRESC_LAST);
    armed_brake_s = bus.en_brake   & ~brake_fin_r;
    armed_rev_s   = bus.en_reverse & ~rev_fin_r;
    armed_fb_s    = bus.en_fbrake  & ~fb_fin_r;
    armed_ut_s    = bus.en_uturn   & ~ut_fin_r;
    if (armed_fb_s)           sel_s = S_FBRAKE;
    else if (armed_brake_s)   sel_s = S_BRAKE;
    else if (armed_rev_s)     sel_s = S_REVERSE;
    else if (armed_ut_s)      sel_s = S_UTURN;
    else if (bus.en_tracking) sel_s = S_TRACK;
    else                      sel_s = S_IDLE;
  end

  // Next state: abort on own request drop, completion beats fbrake preemption.
  always_comb begin
    state_n_s    = state_r;
    done_brake_s = 1'b0;
    done_rev_s   = 1'b0;
    done_fb_s    = 1'b0;
    done_ut_s    = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      S_IDLE, S_TRACK: state_n_s = sel_s;
      S_BRAKE: begin
        if (!bus.en_brake) state_n_s = S_IDLE;
        else if (tick_s && (ticks_r == BRAKE_LAST)) begin
          state_n_s = S_IDLE; done_brake_s = 1'b1;
        end else if (armed_fb_s) state_n_s = S_FBRAKE;
        else state_n_s = S_BRAKE;
      end
      S_REVERSE: begin
        if (!bus.en_reverse) state_n_s = S_IDLE;
        else if (tick_s && (ticks_r == REV_LAST)) begin
          state_n_s = S_IDLE; done_rev_s = 1'b1;
        end else if (armed_fb_s) state_n_s = S_FBRAKE;
        else state_n_s = S_REVERSE;
      end
      S_FBRAKE: begin
        if (!bus.en_fbrake) state_n_s = S_IDLE;
        else if (tick_s && (ticks_r == FB_LAST)) begin
          state_n_s = S_IDLE; done_fb_s = 1'b1;
        end else state_n_s = S_FBRAKE;
      end
      S_UTURN: begin
        if (!bus.en_uturn) state_n_s = S_IDLE;
        else if ((ticks_r >= UT_MIN) && bus.line_center) begin
          state_n_s = S_IDLE; done_ut_s = 1'b1;
        end else if (tick_s && (ticks_r == UT_LAST)) begin
          state_n_s = S_IDLE; done_ut_s = 1'b1; timeout_s = 1'b1;
        end else if (armed_fb_s) state_n_s = S_FBRAKE;
        else state_n_s = S_UTURN;
      end
      default: state_n_s = S_IDLE;
    endcase
  end

  // Motor command targets for the state currently held.
  always_comb begin
    tgt_l_s = 8'd0;
    tgt_r_s = 8'd0;
    dir_l_s = 1'b0;
    dir_r_s = 1'b0;
    brake_s = 1'b0;
    case (state_r)
      S_TRACK:   begin tgt_l_s = bus.trk_duty_l; tgt_r_s = bus.trk_duty_r;
                       dir_l_s = 1'b1; dir_r_s = 1'b1; end
      S_BRAKE,
      S_FBRAKE:  brake_s = 1'b1;
      S_REVERSE: begin tgt_l_s = REV_DUTY; tgt_r_s = REV_DUTY; end
      S_UTURN:   begin tgt_l_s = TURN_DUTY; tgt_r_s = TURN_DUTY; dir_r_s = 1'b1; end
      default:   brake_s = 1'b0;
    endcase
  end

  // State, timers, handshake flags and registered motor outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= S_IDLE;
      presc_r     <= '0;
      ticks_r     <= 16'd0;
      brake_fin_r <= 1'b0;
      rev_fin_r   <= 1'b0;
      fb_fin_r    <= 1'b0;
      ut_fin_r    <= 1'b0;
      ut_to_r     <= 1'b0;
      duty_l_r    <= 8'd0;
      duty_r_r    <= 8'd0;
      dir_l_r     <= 1'b0;
      dir_r_r     <= 1'b0;
      brake_r     <= 1'b0;
`ifdef SOFT_START_EN
      entry_r     <= 1'b0;
`endif
    end else begin
      state_r <= state_n_s;
      if (state_n_s != state_r) begin
        presc_r <= '0;
        ticks_r <= 16'd0;
      end else if (tick_s) begin
        presc_r <= '0;
        if (ticks_r != 16'hFFFF) ticks_r <= ticks_r + 16'd1;
      end else begin
        presc_r <= presc_r + PW'(1);
      end
      // A flag survives only while its request stays high.
      brake_fin_r <= done_brake_s | (bus.en_brake   & brake_fin_r);
      rev_fin_r   <= done_rev_s   | (bus.en_reverse & rev_fin_r);
      fb_fin_r    <= done_fb_s    | (bus.en_fbrake  & fb_fin_r);
      ut_fin_r    <= done_ut_s    | (bus.en_uturn   & ut_fin_r);
      if ((state_n_s == S_UTURN) && (state_r != S_UTURN)) ut_to_r <= 1'b0;
      else if (timeout_s) ut_to_r <= 1'b1;
      else ut_to_r <= ut_to_r;
`ifdef SOFT_START_EN
      entry_r  <= (state_n_s != state_r);
      duty_l_r <= entry_r ? 8'd0 : ramp_step(duty_l_r, tgt_l_s, tick_s);
      duty_r_r <= entry_r ? 8'd0 : ramp_step(duty_r_r, tgt_r_s, tick_s);
`else
      duty_l_r <= tgt_l_s;
      duty_r_r <= tgt_r_s;
`endif
      dir_l_r  <= dir_l_s;
      dir_r_r  <= dir_r_s;
      brake_r  <= brake_s;
    end
  end

  assign bus.duty_l           = duty_l_r;
  assign bus.duty_r           = duty_r_r;
  assign bus.dir_l            = dir_l_r;
  assign bus.dir_r            = dir_r_r;
  assign bus.motor_brake      = brake_r;
  assign bus.brake_finished   = brake_fin_r;
  assign bus.reverse_finished = rev_fin_r;
  assign bus.fbrake_finished  = fb_fin_r;
  assign bus.uturn_finished   = ut_fin_r;
  assign bus.uturn_timeout    = ut_to_r;

endmodule

// File: tb/tb_motion_sequencer.sv
// Directed bench for motion_sequencer with short timing parameters.
module tb_motion_sequencer;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  motion_sequencer_if bus ();

  motion_sequencer #(
    .TICK_DIV(4), .BRAKE_T(3), .REVERSE_T(6), .FBRAKE_T(3),
    .UTURN_MIN_T(2), .UTURN_MAX_T(5), .REV_DUTY(8'd120), .TURN_DUTY(8'd140)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // {duty_l, duty_r, dir_l, dir_r, motor_brake}
  logic [18:0] mot;
  // {brake, reverse, fbrake, uturn finished, uturn_timeout}
  logic [4:0]  flg;
  assign mot = {bus.duty_l, bus.duty_r, bus.dir_l, bus.dir_r, bus.motor_brake};
  assign flg = {bus.brake_finished, bus.reverse_finished, bus.fbrake_finished,
                bus.uturn_finished, bus.uturn_timeout};

  localparam logic [18:0] MOT_IDLE  = 19'd0;
  localparam logic [18:0] MOT_TRACK = {8'd50, 8'd60, 1'b1, 1'b1, 1'b0};
  localparam logic [18:0] MOT_BRAKE = {8'd0, 8'd0, 1'b0, 1'b0, 1'b1};
  localparam logic [18:0] MOT_REV   = {8'd120, 8'd120, 1'b0, 1'b0, 1'b0};
  localparam logic [18:0] MOT_UTURN = {8'd140, 8'd140, 1'b0, 1'b1, 1'b0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0;
    bus.en_tracking = 1'b0; bus.en_brake = 1'b0; bus.en_reverse = 1'b0;
    bus.en_fbrake = 1'b0; bus.en_uturn = 1'b0; bus.line_center = 1'b0;
    bus.trk_duty_l = 8'd0; bus.trk_duty_r = 8'd0;
    repeat (3) @(negedge clk);
    tests++;
    if (mot !== MOT_IDLE) begin
      $display("FAIL reset_motor: got %h expected %h", mot, MOT_IDLE); fails++;
    end
    tests++;
    if (flg !== 5'b00000) begin
      $display("FAIL reset_flags: got %b expected %b", flg, 5'b00000); fails++;
    end
    rst = 1'b1;
    bus.en_tracking = 1'b1; bus.trk_duty_l = 8'd50; bus.trk_duty_r = 8'd60;
    repeat (2) @(negedge clk);
    tests++;
    if (mot !== MOT_TRACK) begin
      $display("FAIL track_passthrough: got %h expected %h", mot, MOT_TRACK); fails++;
    end
  endtask

  task automatic test_brake();
    bus.en_tracking = 1'b0;
    bus.en_brake    = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 2) begin
        tests++;
        if (mot !== MOT_BRAKE) begin
          $display("FAIL brake_motor: got %h expected %h", mot, MOT_BRAKE); fails++;
        end
      end
      if (k == 12) begin
        tests++;
        if (flg !== 5'b00000) begin
          $display("FAIL brake_early: got %b expected %b", flg, 5'b00000); fails++;
        end
      end
      if (k == 13) begin
        tests++;
        if (flg !== 5'b10000) begin
          $display("FAIL brake_done_12: got %b expected %b", flg, 5'b10000); fails++;
        end
      end
      if (k == 14) begin
        tests++;
        if (mot !== MOT_IDLE) begin
          $display("FAIL brake_to_idle: got %h expected %h", mot, MOT_IDLE); fails++;
        end
      end
    end
    tests++;
    if (flg !== 5'b10000) begin
      $display("FAIL brake_flag_hold: got %b expected %b", flg, 5'b10000); fails++;
    end
    bus.en_brake = 1'b0;
    @(negedge clk);
    tests++;
    if (flg !== 5'b00000) begin
      $display("FAIL brake_flag_clear: got %b expected %b", flg, 5'b00000); fails++;
    end
  endtask

  task automatic test_brake_then_uturn();
    bus.en_brake = 1'b1;
    bus.en_uturn = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 2) begin
        tests++;
        if (mot !== MOT_BRAKE) begin
          $display("FAIL combo_brake_first: got %h expected %h", mot, MOT_BRAKE); fails++;
        end
      end
      if (k == 13) begin
        tests++;
        if (flg !== 5'b10000) begin
          $display("FAIL combo_brake_done: got %b expected %b", flg, 5'b10000); fails++;
        end
      end
      if (k == 14) begin
        tests++;
        if (mot !== MOT_IDLE) begin
          $display("FAIL combo_idle_gap: got %h expected %h", mot, MOT_IDLE); fails++;
        end
      end
      if (k == 15) begin
        tests++;
        if (mot !== MOT_UTURN) begin
          $display("FAIL combo_uturn_start: got %h expected %h", mot, MOT_UTURN); fails++;
        end
      end
      if (k == 16) begin
        bus.en_brake = 1'b0;
        bus.en_uturn = 1'b0;
      end
      if (k == 17) begin
        tests++;
        if (flg !== 5'b00000) begin
          $display("FAIL uturn_abort_flags: got %b expected %b", flg, 5'b00000); fails++;
        end
      end
      if (k == 18) begin
        tests++;
        if (mot !== MOT_IDLE) begin
          $display("FAIL uturn_abort_idle: got %h expected %h", mot, MOT_IDLE); fails++;
        end
      end
    end
  endtask

  task automatic test_uturn_timeout();
    bus.line_center = 1'b0;
    bus.en_uturn    = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (k == 20) begin
        tests++;
        if (flg !== 5'b00000) begin
          $display("FAIL timeout_early: got %b expected %b", flg, 5'b00000); fails++;
        end
      end
      if (k == 21) begin
        tests++;
        if (flg !== 5'b00011) begin
          $display("FAIL timeout_at_20: got %b expected %b", flg, 5'b00011); fails++;
        end
      end
    end
    bus.en_uturn = 1'b0;
    @(negedge clk);
    tests++;
    if (flg !== 5'b00001) begin
      $display("FAIL timeout_sticky: got %b expected %b", flg, 5'b00001); fails++;
    end
  endtask

  task automatic test_uturn_min();
    bus.line_center = 1'b0;
    bus.en_uturn    = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        tests++;
        if (flg !== 5'b00000) begin
          $display("FAIL timeout_clear_entry: got %b expected %b", flg, 5'b00000); fails++;
        end
      end
      if (k == 5) bus.line_center = 1'b1;
      if (k == 6 || k == 9) begin
        tests++;
        if ({mot, flg} !== {MOT_UTURN, 5'b00000}) begin
          $display("FAIL uturn_before_min k=%0d: got %h expected %h", k, {mot, flg},
                   {MOT_UTURN, 5'b00000}); fails++;
        end
      end
      if (k == 10) begin
        tests++;
        if (flg !== 5'b00010) begin
          $display("FAIL uturn_min_exit: got %b expected %b", flg, 5'b00010); fails++;
        end
      end
    end
    bus.en_uturn    = 1'b0;
    bus.line_center = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fbrake_preempt_reset();
    bus.en_reverse = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 2) begin
        tests++;
        if (mot !== MOT_REV) begin
          $display("FAIL reverse_motor: got %h expected %h", mot, MOT_REV); fails++;
        end
      end
      if (k == 3) bus.en_fbrake = 1'b1;
      if (k == 5) begin
        tests++;
        if ({mot, flg} !== {MOT_BRAKE, 5'b00000}) begin
          $display("FAIL fbrake_preempt: got %h expected %h", {mot, flg},
                   {MOT_BRAKE, 5'b00000}); fails++;
        end
      end
    end
    rst = 1'b0;
    #1;
    tests++;
    if ({mot, flg} !== 24'd0) begin
      $display("FAIL async_reset: got %h expected %h", {mot, flg}, 24'd0); fails++;
    end
    bus.en_reverse = 1'b0;
    bus.en_fbrake  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({mot, flg} !== 24'd0) begin
      $display("FAIL post_reset_idle: got %h expected %h", {mot, flg}, 24'd0); fails++;
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_brake();
    test_brake_then_uturn();
    test_uturn_timeout();
    test_uturn_min();
    test_fbrake_preempt_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
